// File: rtl/alu_lockstep_sched.sv
// alu_lockstep_sched
//
// Purpose: sequencer and self-test controller for a dual 4-bit lockstep ALU
// datapath. It drives identical operands and op-selects to both ALUs. This
// happens either once (single-vector mode) or across all 1024 {sel,a,b}
// combinations (sweep mode). After ALU_LAT cycles it samples the XOR-compare
// outputs, keeps a saturating mismatch count and captures the first failing
// vector. A fault-inject bit flips the LSB of ALU2's B operand for a whole run,
// so the checker itself can be exercised.
//
// Ports:
//   wb_clk_i, wb_rst_ni         clock, asynchronous active-low reset
//   start_i, abort_i            run control (start sampled only when idle)
//   mode_i                      0 = single vector, 1 = full sweep
//   cfg_a_i, cfg_b_i, cfg_sel_i single-mode operands and op select
//   inject_i                    flip LSB of ALU2 operand B for the run
//   a0_o, b0_o, sel1_o          ALU1 operands / op select
//   a1_o, b1_o, sel2_o          ALU2 operands / op select
//   x_i, y_i                    result / carry XOR compare from the datapath
//   busy_o, done_o, pass_o      run status
//   err_cnt_o                   saturating mismatch count
//   fail_vec_o, fail_x_o, fail_y_o  first failing {sel,a,b} and its compare
module alu_lockstep_sched #(
  parameter int ALU_LAT      = 1,
  parameter int ERR_W        = 8,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             mode_i,
  input  logic [3:0]       cfg_a_i,
  input  logic [3:0]       cfg_b_i,
  input  logic [1:0]       cfg_sel_i,
  input  logic             inject_i,
  output logic [3:0]       a0_o,
  output logic [3:0]       b0_o,
  output logic [3:0]       a1_o,
  output logic [3:0]       b1_o,
  output logic [1:0]       sel1_o,
  output logic [1:0]       sel2_o,
  input  logic [3:0]       x_i,
  input  logic             y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [9:0]       fail_vec_o,
  output logic [3:0]       fail_x_o,
  output logic             fail_y_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRIVE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  // WAIT counts down from ALU_LAT-2 to 0, so it lasts ALU_LAT-1 cycles.
  localparam logic [1:0] WAIT_INIT = (ALU_LAT > 1) ? 2'(ALU_LAT - 2) : 2'd0;
  localparam logic [9:0] VEC_LAST  = 10'h3ff;

  logic [2:0]       state;
  logic [9:0]       vec;
  logic             mode_q;
  logic             inj_q;
  logic [1:0]       wait_cnt;

  logic             mism;
  logic             last_vec;
  logic             first_fail;
  logic [ERR_W-1:0] err_next;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + 1'b1;
  endfunction

  // In single mode the configured vector is loaded into vec at start, so the
  // sweep and single paths share the same DRIVE/CHECK logic.
  always_comb begin
    mism       = (|x_i) | y_i;
    last_vec   = !mode_q || (vec == VEC_LAST);
    // err_cnt is cleared at start and never wraps, so zero means no failure yet.
    first_fail = mism && (err_cnt_o == '0);
    err_next   = mism ? sat_inc(err_cnt_o) : err_cnt_o;
  end

  assign busy_o = (state != S_IDLE);
  assign done_o = (state == S_FIN);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state      <= S_IDLE;
      vec        <= '0;
      mode_q     <= 1'b0;
      inj_q      <= 1'b0;
      wait_cnt   <= '0;
      a0_o       <= '0;
      b0_o       <= '0;
      a1_o       <= '0;
      b1_o       <= '0;
      sel1_o     <= '0;
      sel2_o     <= '0;
      pass_o     <= 1'b0;
      err_cnt_o  <= '0;
      fail_vec_o <= '0;
      fail_x_o   <= '0;
      fail_y_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            mode_q     <= mode_i;
            inj_q      <= inject_i;
            vec        <= mode_i ? 10'd0 : {cfg_sel_i, cfg_a_i, cfg_b_i};
            err_cnt_o  <= '0;
            fail_vec_o <= '0;
            fail_x_o   <= '0;
            fail_y_o   <= 1'b0;
            pass_o     <= 1'b0;
            state      <= S_DRIVE;
          end
        end

        // Drive stage: operands registered toward both ALUs
        S_DRIVE: begin
          if (abort_i) begin
            state <= S_IDLE;
          end else begin
            a0_o   <= vec[7:4];
            a1_o   <= vec[7:4];
            b0_o   <= vec[3:0];
            b1_o   <= vec[3:0] ^ {3'b000, inj_q};
            sel1_o <= vec[9:8];
            sel2_o <= vec[9:8];
            if (ALU_LAT > 1) begin
              wait_cnt <= WAIT_INIT;
              state    <= S_WAIT;
            end else begin
              state <= S_CHECK;
            end
          end
        end

        // Wait stage: datapath latency beyond the first cycle
        S_WAIT: begin
          if (abort_i) begin
            state <= S_IDLE;
          end else if (wait_cnt == 2'd0) begin
            state <= S_CHECK;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end

        // Check stage: compare sampled; counted even when aborting here
        S_CHECK: begin
          err_cnt_o <= err_next;
          if (first_fail) begin
            fail_vec_o <= {sel1_o, a0_o, b0_o};
            fail_x_o   <= x_i;
            fail_y_o   <= y_i;
          end
          if (abort_i) begin
            state <= S_IDLE;
          end else if (last_vec || (mism && (STOP_ON_FAIL != 0))) begin
            pass_o <= (err_next == '0);
            state  <= S_FIN;
          end else begin
            vec   <= vec + 10'd1;
            state <= S_DRIVE;
          end
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_lockstep_sched.sv
// Bench for alu_lockstep_sched. There are two instances: the defaults
// (ALU_LAT=1, ERR_W=8, STOP_ON_FAIL=0) and a stop-on-fail variant with
// ALU_LAT=3, ERR_W=4. Each instance sits behind its own behavioural lockstep
// ALU stub, which can force a result fault at one vector or hold the carry
// compare stuck high. Expected results come from a vector-loop reference model.
module tb_alu_lockstep_sched;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort, mode, inject;
  logic [3:0] cfg_a, cfg_b;
  logic [1:0] cfg_sel;

  // stub fault configuration
  logic       fault_en;
  logic [9:0] fault_vec;
  logic       stuck_y;

  int checks = 0;
  int errors = 0;

  // default instance
  logic [3:0] d_a0, d_b0, d_a1, d_b1, d_x, d_fx;
  logic [1:0] d_s1, d_s2;
  logic       d_y, d_busy, d_done, d_pass, d_fy;
  logic [7:0] d_err;
  logic [9:0] d_fvec;
  logic [4:0] d_r0, d_r1;

  // stop-on-fail instance
  logic [3:0] s_a0, s_b0, s_a1, s_b1, s_x, s_fx;
  logic [1:0] s_s1, s_s2;
  logic       s_y, s_busy, s_done, s_pass, s_fy;
  logic [3:0] s_err;
  logic [9:0] s_fvec;
  logic [4:0] s_r0, s_r1;

  alu_lockstep_sched u_dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .mode_i(mode), .cfg_a_i(cfg_a), .cfg_b_i(cfg_b), .cfg_sel_i(cfg_sel),
    .inject_i(inject), .a0_o(d_a0), .b0_o(d_b0), .a1_o(d_a1), .b1_o(d_b1),
    .sel1_o(d_s1), .sel2_o(d_s2), .x_i(d_x), .y_i(d_y), .busy_o(d_busy),
    .done_o(d_done), .pass_o(d_pass), .err_cnt_o(d_err), .fail_vec_o(d_fvec),
    .fail_x_o(d_fx), .fail_y_o(d_fy)
  );

  alu_lockstep_sched #(.ALU_LAT(3), .ERR_W(4), .STOP_ON_FAIL(1)) u_stop (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .mode_i(mode), .cfg_a_i(cfg_a), .cfg_b_i(cfg_b), .cfg_sel_i(cfg_sel),
    .inject_i(inject), .a0_o(s_a0), .b0_o(s_b0), .a1_o(s_a1), .b1_o(s_b1),
    .sel1_o(s_s1), .sel2_o(s_s2), .x_i(s_x), .y_i(s_y), .busy_o(s_busy),
    .done_o(s_done), .pass_o(s_pass), .err_cnt_o(s_err), .fail_vec_o(s_fvec),
    .fail_x_o(s_fx), .fail_y_o(s_fy)
  );

  // 4-bit ALU: add, subtract, and, or; bit 4 is carry/borrow
  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] s);
    case (s)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  // lockstep datapath stubs (combinational; operands are held through WAIT)
  assign d_r0 = alu_f(d_a0, d_b0, d_s1);
  assign d_r1 = alu_f(d_a1, d_b1, d_s2);
  assign d_x  = d_r0[3:0] ^ d_r1[3:0] ^
                ((fault_en && {d_s1, d_a0, d_b0} == fault_vec) ? 4'b0100 : 4'b0000);
  assign d_y  = d_r0[4] ^ d_r1[4] ^ stuck_y;
  assign s_r0 = alu_f(s_a0, s_b0, s_s1);
  assign s_r1 = alu_f(s_a1, s_b1, s_s2);
  assign s_x  = s_r0[3:0] ^ s_r1[3:0] ^
                ((fault_en && {s_s1, s_a0, s_b0} == fault_vec) ? 4'b0100 : 4'b0000);
  assign s_y  = s_r0[4] ^ s_r1[4] ^ stuck_y;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk the vectors the run visits and apply the compare rules.
  task automatic model(input logic md, input logic [9:0] cfg, input logic inj,
                       input int lim, input int stop, input int errw, input int lat,
                       output int e_err, output int e_fvec, output int e_fx,
                       output int e_fy, output int e_pass, output int e_edges,
                       output int e_last);
    int first, last, n;
    logic [9:0] vv;
    logic [4:0] r0, r1;
    logic [3:0] x;
    logic       y;
    bit         seen;
    first = md ? 0 : int'(cfg);
    last  = md ? lim : int'(cfg);
    e_err = 0; e_fvec = 0; e_fx = 0; e_fy = 0; e_last = first;
    n = 0; seen = 0;
    for (int v = first; v <= last; v++) begin
      vv = v[9:0];
      r0 = alu_f(vv[7:4], vv[3:0], vv[9:8]);
      r1 = alu_f(vv[7:4], vv[3:0] ^ {3'b000, inj}, vv[9:8]);
      x  = r0[3:0] ^ r1[3:0];
      if (fault_en && vv == fault_vec) x = x ^ 4'b0100;
      y  = r0[4] ^ r1[4] ^ stuck_y;
      n++;
      e_last = v;
      if (x != 4'd0 || y) begin
        if (!seen) begin
          seen = 1; e_fvec = v; e_fx = int'(x); e_fy = int'(y);
        end
        if (e_err < (1 << errw) - 1) e_err++;
        if (stop != 0) break;
      end
    end
    e_pass  = (e_err == 0);
    e_edges = n * (lat + 1) + 1;
  endtask

  // Raise start on a falling edge and drop it after one rising edge.
  task automatic start_run(input logic md, input logic [9:0] cfg, input logic inj);
    @(negedge clk);
    mode = md; {cfg_sel, cfg_a, cfg_b} = cfg; inject = inj; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_run(input string nm, input logic md, input logic [9:0] cfg,
                        input logic inj);
    int de_err, de_fvec, de_fx, de_fy, de_pass, de_edges, de_last;
    int se_err, se_fvec, se_fx, se_fy, se_pass, se_edges, se_last;
    int edges, d_at, s_at, d_cnt, s_cnt;
    logic [9:0] fv;
    model(md, cfg, inj, 1023, 0, 8, 1, de_err, de_fvec, de_fx, de_fy, de_pass, de_edges, de_last);
    model(md, cfg, inj, 1023, 1, 4, 3, se_err, se_fvec, se_fx, se_fy, se_pass, se_edges, se_last);
    fv = md ? 10'd0 : cfg;
    start_run(md, cfg, inj);
    edges = 1; d_at = 0; s_at = 0; d_cnt = 0; s_cnt = 0;
    chk({nm, " busy_d"}, d_busy, 1);
    chk({nm, " busy_s"}, s_busy, 1);
    while (edges < 6000) begin
      @(negedge clk);
      edges++;
      if (edges == 2) begin
        chk({nm, " first_vec_d"}, {d_s1, d_a0, d_b0}, fv);
        chk({nm, " first_vec_s"}, {s_s1, s_a0, s_b0}, fv);
      end
      if (d_done) begin d_cnt++; if (d_at == 0) d_at = edges; end
      if (s_done) begin s_cnt++; if (s_at == 0) s_at = edges; end
      if (d_at != 0 && s_at != 0 && edges > d_at + 2 && edges > s_at + 2) break;
    end
    chk({nm, " done_at_d"}, d_at, de_edges);
    chk({nm, " done_at_s"}, s_at, se_edges);
    chk({nm, " done_cnt_d"}, d_cnt, 1);
    chk({nm, " done_cnt_s"}, s_cnt, 1);
    chk({nm, " busy_end_d"}, d_busy, 0);
    chk({nm, " err_d"}, d_err, de_err);
    chk({nm, " err_s"}, s_err, se_err);
    chk({nm, " pass_d"}, d_pass, de_pass);
    chk({nm, " pass_s"}, s_pass, se_pass);
    chk({nm, " fail_d"}, {d_fvec, d_fx, d_fy}, {de_fvec[9:0], de_fx[3:0], de_fy[0]});
    chk({nm, " fail_s"}, {s_fvec, s_fx, s_fy}, {se_fvec[9:0], se_fx[3:0], se_fy[0]});
    chk({nm, " alu1_d"}, {d_s1, d_a0, d_b0}, de_last[9:0]);
    chk({nm, " alu2_d"}, {d_s2, d_a1, d_b1}, de_last[9:0] ^ {9'd0, inj});
    chk({nm, " alu1_s"}, {s_s1, s_a0, s_b0}, se_last[9:0]);
    chk({nm, " alu2_s"}, {s_s2, s_a1, s_b1}, se_last[9:0] ^ {9'd0, inj});
  endtask

  initial begin
    int e_err, e_fvec, e_fx, e_fy, e_pass, e_edges, e_last, n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; inject = 1'b0;
    cfg_a = '0; cfg_b = '0; cfg_sel = '0;
    fault_en = 1'b0; fault_vec = '0; stuck_y = 1'b0;
    #12;
    chk("rst_d_ops", {d_a0, d_b0, d_a1, d_b1, d_s1, d_s2}, 0);
    chk("rst_d_stat", {d_busy, d_done, d_pass, d_err, d_fvec, d_fx, d_fy}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_run("single_35", 1'b0, {2'b01, 4'h3, 4'h5}, 1'b0);
    do_run("single_inj", 1'b0, {2'b00, 4'h2, 4'h6}, 1'b1);

    fault_en = 1'b1; fault_vec = 10'h155;
    do_run("sweep_x155", 1'b1, 10'd0, 1'b0);

    fault_en = 1'b0; stuck_y = 1'b1;
    do_run("sweep_stuck_y", 1'b1, 10'd0, 1'b0);
    stuck_y = 1'b0;

    fault_en = 1'b1; fault_vec = 10'($urandom_range(0, 1023));
    do_run("sweep_inj", 1'b1, 10'd0, 1'b1);

    // abort at vector 0x080 of a sweep while the default instance is in CHECK
    fault_en = 1'b1; fault_vec = 10'h055;
    start_run(1'b1, 10'd0, 1'b0);
    n = 0;
    while ({d_s1, d_a0, d_b0} != 10'h080 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach", ({d_s1, d_a0, d_b0} == 10'h080), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    model(1'b1, 10'd0, 1'b0, 10'h080, 0, 8, 1, e_err, e_fvec, e_fx, e_fy, e_pass, e_edges, e_last);
    chk("abort_busy_d", d_busy, 0);
    chk("abort_busy_s", s_busy, 0);
    chk("abort_err_d", d_err, e_err);
    chk("abort_fail_d", {d_fvec, d_fx, d_fy}, {e_fvec[9:0], e_fx[3:0], e_fy[0]});
    n = 0;
    repeat (4) begin
      @(negedge clk);
      n += int'(d_done) + int'(s_done);
    end
    chk("abort_no_done", n, 0);
    chk("abort_pass_d", d_pass, 0);

    // asynchronous reset in the middle of a sweep
    fault_en = 1'b0;
    start_run(1'b1, 10'd0, 1'b0);
    n = 0;
    while ({d_s1, d_a0, d_b0} != 10'h200 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach", ({d_s1, d_a0, d_b0} == 10'h200), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_d_ops", {d_a0, d_b0, d_a1, d_b1, d_s1, d_s2}, 0);
    chk("midrst_d_stat", {d_busy, d_done, d_pass, d_err, d_fvec, d_fx, d_fy}, 0);
    chk("midrst_s_stat", {s_busy, s_done, s_pass, s_err, s_a0, s_b0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_run("sweep_after_rst", 1'b1, 10'd0, 1'b0);

    // randomized single-vector runs
    for (int i = 0; i < 16; i++) begin
      logic [9:0] c;
      c = 10'($urandom_range(0, 1023));
      fault_en  = 1'($urandom_range(0, 1));
      fault_vec = ($urandom_range(0, 1) != 0) ? c : 10'($urandom_range(0, 1023));
      stuck_y   = ($urandom_range(0, 7) == 0);
      do_run("rand_single", 1'b0, c, 1'($urandom_range(0, 1)));
    end
    stuck_y = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
